// File: rtl/fifo72_tx_arb_pkg.sv
// Shared XGMII word constants, word classification helpers and FSM encoding
// for the frame-level 72-bit TX arbiter.
package fifo72_tx_arb_pkg;

  localparam logic [71:0] XGMII_IDLE_WORD  = 72'hFF_0707070707070707;
  localparam logic [71:0] XGMII_ABORT_WORD = 72'hFF_07070707070707FD;
  localparam logic [7:0]  XGMII_SOF_CTRL   = 8'h01;
  localparam logic [7:0]  XGMII_ALL_CTRL   = 8'hFF;
  localparam logic [7:0]  XGMII_START      = 8'hFB;
  localparam logic [7:0]  XGMII_TERM       = 8'hFD;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  function automatic logic is_sof(input logic [71:0] w);
    return (w[71:64] == XGMII_SOF_CTRL) && (w[7:0] == XGMII_START);
  endfunction

  // Terminate may sit in any lane, so scan all eight control/byte pairs.
  function automatic logic is_eof(input logic [71:0] w);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hit = hit | (w[64+i] & (w[8*i +: 8] == XGMII_TERM));
    end
    return hit;
  endfunction

  function automatic logic is_idle(input logic [71:0] w);
    return (w[71:64] == XGMII_ALL_CTRL) && !is_eof(w);
  endfunction

endpackage

// File: rtl/fifo72_tx_arb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after the last
// winner (wrapping modulo NPORT), returned as one-hot grant plus index.
module fifo72_tx_arb_rr_pick #(
  parameter int NPORT = 4,
  parameter int IW    = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [NPORT-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [IW-1:0] pos_s;
  logic          hit_s;

  // Walk the ports from last+1 around to last; the first hit locks the result.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos_s = '0;
    hit_s = 1'b0;
    for (int k = 1; k <= NPORT; k++) begin
      pos_s      = IW'((int'(last) + k) % NPORT);
      hit_s      = ~valid & req[pos_s];
      gnt[pos_s] = gnt[pos_s] | hit_s;
      idx        = hit_s ? pos_s : idx;
      valid      = valid | hit_s;
    end
  end

endmodule

// File: rtl/fifo72_tx_arb.sv
// Frame-level round-robin arbiter merging NPORT FWFT XGMII-word FIFOs into one
// FWFT read interface; whole frames only, with garbage resync and truncation.
module fifo72_tx_arb
  import fifo72_tx_arb_pkg::*;
#(
  parameter int NPORT     = 4,
  parameter int MAX_WORDS = 194
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NPORT*72-1:0] in_dout,
  input  logic [NPORT-1:0]    in_empty,
  output logic [NPORT-1:0]    in_rd_en,
  output logic [71:0]         out_dout,
  output logic                out_empty,
  input  logic                out_rd_en,
  output logic [NPORT-1:0]    grant,
  output logic [31:0]         frames_sent,
  output logic [15:0]         drop_cnt
);

  localparam int IW = $clog2(NPORT);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int DW = $clog2(NPORT + 1);

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [NPORT-1:0] grant_r;
  logic [IW-1:0]    gidx_r;
  logic [IW-1:0]    rr_r;
  logic [CW-1:0]    cnt_r;
  logic [71:0]      ob_r;
  logic             ob_valid_r;
  logic [31:0]      frames_r;
  logic [15:0]      drop_r;

  logic [71:0]      head_s [NPORT];
  logic [NPORT-1:0] sof_req_s;
  logic [NPORT-1:0] arb_pop_s;
  logic [NPORT-1:0] arb_data_s;
  logic [DW-1:0]    data_cnt_s;
  logic [NPORT-1:0] pick_gnt_s;
  logic [IW-1:0]    pick_idx_s;
  logic             pick_valid_s;
  logic             ld_s;
  logic [71:0]      g_head_s;
  logic             g_empty_s;
  logic             g_eof_s;
  logic [NPORT-1:0] rd_en_s;
  logic             ob_ld_s;
  logic [71:0]      ob_din_s;
  logic             cnt_inc_s;
  logic             frame_done_s;
  logic             abort_s;
  logic             drain_done_s;
  logic [DW-1:0]    drop_add_s;
  logic [16:0]      drop_sum_s;

  // Unpack heads; in ARB every non-SOF head is garbage, only DATA is counted.
  always_comb begin
    data_cnt_s = '0;
    for (int p = 0; p < NPORT; p++) begin
      head_s[p]     = in_dout[72*p +: 72];
      sof_req_s[p]  = ~in_empty[p] & is_sof(in_dout[72*p +: 72]);
      arb_pop_s[p]  = ~in_empty[p] & ~is_sof(in_dout[72*p +: 72]);
      arb_data_s[p] = arb_pop_s[p] & ~is_idle(in_dout[72*p +: 72]);
      data_cnt_s    = data_cnt_s + DW'(arb_data_s[p]);
    end
  end

  fifo72_tx_arb_rr_pick #(
    .NPORT (NPORT),
    .IW    (IW)
  ) u_rr_pick (
    .req   (sof_req_s),
    .last  (rr_r),
    .gnt   (pick_gnt_s),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  assign ld_s       = ~ob_valid_r | out_rd_en;
  assign g_head_s   = head_s[gidx_r];
  assign g_empty_s  = in_empty[gidx_r];
  assign g_eof_s    = is_eof(g_head_s);
  assign drop_sum_s = {1'b0, drop_r} + 17'(drop_add_s);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r <= ST_ARB;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ARB: begin
        if (pick_valid_s) state_nxt_s = ST_SEND;
        else              state_nxt_s = ST_ARB;
      end
      ST_SEND: begin
        if (abort_s)           state_nxt_s = ST_DRAIN;
        else if (frame_done_s) state_nxt_s = ST_ARB;
        else                   state_nxt_s = ST_SEND;
      end
      ST_DRAIN: begin
        if (drain_done_s) state_nxt_s = ST_ARB;
        else              state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_ARB;
    endcase
  end

  // FSM outputs: source pops, output-buffer load and per-cycle event strobes.
  always_comb begin
    rd_en_s      = '0;
    ob_ld_s      = 1'b0;
    ob_din_s     = ob_r;
    cnt_inc_s    = 1'b0;
    frame_done_s = 1'b0;
    abort_s      = 1'b0;
    drain_done_s = 1'b0;
    drop_add_s   = '0;
    case (state_r)
      ST_ARB: begin
        rd_en_s    = arb_pop_s;
        drop_add_s = data_cnt_s;
      end
      ST_SEND: begin
        // Length limit is checked before the source so a stalled source cannot dodge it.
        if (ld_s && (cnt_r == CW'(MAX_WORDS))) begin
          ob_ld_s  = 1'b1;
          ob_din_s = XGMII_ABORT_WORD;
          abort_s  = 1'b1;
        end else if (ld_s && !g_empty_s) begin
          rd_en_s      = grant_r;
          ob_ld_s      = 1'b1;
          ob_din_s     = g_head_s;
          cnt_inc_s    = 1'b1;
          frame_done_s = g_eof_s;
        end else begin
          rd_en_s = '0;
        end
      end
      ST_DRAIN: begin
        if (!g_empty_s) begin
          rd_en_s      = grant_r;
          drop_add_s   = DW'(1'b1);
          drain_done_s = g_eof_s;
        end else begin
          rd_en_s = '0;
        end
      end
      default: rd_en_s = '0;
    endcase
  end

  // Grant, round-robin pointer and in-frame word count.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      grant_r <= '0;
      gidx_r  <= '0;
      rr_r    <= IW'(NPORT - 1);
      cnt_r   <= '0;
    end else if ((state_r == ST_ARB) && pick_valid_s) begin
      grant_r <= pick_gnt_s;
      gidx_r  <= pick_idx_s;
      cnt_r   <= '0;
    end else if (frame_done_s || drain_done_s) begin
      grant_r <= '0;
      rr_r    <= gidx_r;
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  // Single-entry output buffer presenting the FWFT head word.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ob_r       <= XGMII_IDLE_WORD;
      ob_valid_r <= 1'b0;
    end else if (ob_ld_s) begin
      ob_r       <= ob_din_s;
      ob_valid_r <= 1'b1;
    end else if (out_rd_en) begin
      ob_valid_r <= 1'b0;
    end
  end

  // Status counters: completed frames wrap, dropped words saturate.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      frames_r <= 32'd0;
      drop_r   <= 16'd0;
    end else begin
      if (frame_done_s) frames_r <= frames_r + 32'd1;
      drop_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end
  end

  // Pops are held off while reset is asserted so no word leaves uncounted.
  assign in_rd_en    = rd_en_s & {NPORT{sys_rst}};
  assign out_dout    = ob_r;
  assign out_empty   = ~ob_valid_r;
  assign grant       = grant_r;
  assign frames_sent = frames_r;
  assign drop_cnt    = drop_r;

endmodule

// File: tb/tb_fifo72_tx_arb.sv
// Directed bench for fifo72_tx_arb: queue-modelled FWFT sources, captured
// output stream compared against hand-built expected frame sequences.
`timescale 1ns/1ps
module tb_fifo72_tx_arb;
  import fifo72_tx_arb_pkg::*;

  localparam int NPORT     = 4;
  localparam int MAX_WORDS = 194;

  logic                sys_clk = 1'b0;
  logic                sys_rst = 1'b0;
  logic [NPORT*72-1:0] in_dout = '0;
  logic [NPORT-1:0]    in_empty = '1;
  logic [NPORT-1:0]    in_rd_en;
  logic [71:0]         out_dout;
  logic                out_empty;
  logic                out_rd_en = 1'b0;
  logic [NPORT-1:0]    grant;
  logic [31:0]         frames_sent;
  logic [15:0]         drop_cnt;

  logic [71:0] src_q [NPORT][$];
  logic [71:0] exp_q [$];
  logic [71:0] obs_q [$];
  logic [NPORT-1:0] rd_cap;
  logic [71:0] dout_cap;
  int tests_run = 0;
  int tests_failed = 0;
  int underflow = 0;
  int cyc = 0;
  int first_valid_cyc = -1;

  always #5 sys_clk = ~sys_clk;

  fifo72_tx_arb #(
    .NPORT     (NPORT),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .in_dout     (in_dout),
    .in_empty    (in_empty),
    .in_rd_en    (in_rd_en),
    .out_dout    (out_dout),
    .out_empty   (out_empty),
    .out_rd_en   (out_rd_en),
    .grant       (grant),
    .frames_sent (frames_sent),
    .drop_cnt    (drop_cnt)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] gen_word(input int p, input int id, input int n, input int i);
    if (i == 0)     return {8'h01, 4'(p), 4'(id), 48'h555555555555, 8'hFB};
    if (i == n - 1) return {8'hF8, 32'h07070707, 8'hFD, 4'(p), 4'(id), 16'hE0F0};
    return {8'h00, 4'(p), 4'(id), 40'h0, 16'(i)};
  endfunction

  task automatic push_src(input int p, input int id, input int n);
    for (int i = 0; i < n; i++) src_q[p].push_back(gen_word(p, id, n, i));
  endtask

  task automatic push_exp(input int p, input int id, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(gen_word(p, id, n, i));
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NPORT; p++) begin
      if (src_q[p].size() > 0) begin
        in_dout[72*p +: 72] = src_q[p][0];
        in_empty[p] = 1'b0;
      end else begin
        in_dout[72*p +: 72] = XGMII_IDLE_WORD;
        in_empty[p] = 1'b1;
      end
    end
  endtask

  // Entered and left at a falling edge; the DUT edge happens in the middle.
  task automatic cycle();
    logic [71:0] tmp;
    drive_inputs();
    #1;
    rd_cap   = in_rd_en;
    dout_cap = out_dout;
    if (out_rd_en && !out_empty) obs_q.push_back(out_dout);
    if (!out_empty && first_valid_cyc < 0) first_valid_cyc = cyc;
    @(posedge sys_clk);
    for (int p = 0; p < NPORT; p++) begin
      if (rd_cap[p]) begin
        if (src_q[p].size() > 0) tmp = src_q[p].pop_front();
        else underflow++;
      end
    end
    cyc++;
    @(negedge sys_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    for (int p = 0; p < NPORT; p++) src_q[p].delete();
    obs_q.delete();
    exp_q.delete();
    drive_inputs();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
  endtask

  task automatic compare_out(input string tag);
    int n;
    chk({tag, "_len"}, 72'(obs_q.size()), 72'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, n, pops, changes, leftover;
    logic [71:0] held;

    @(negedge sys_clk);
    do_reset();
    #1;
    chk("rst_out_empty", 72'(out_empty), 72'(1));
    chk("rst_out_dout", out_dout, XGMII_IDLE_WORD);
    chk("rst_grant", 72'(grant), 72'(0));
    chk("rst_frames", 72'(frames_sent), 72'(0));
    chk("rst_drop", 72'(drop_cnt), 72'(0));
    chk("rst_rd_en", 72'(in_rd_en), 72'(0));
    @(negedge sys_clk);

    // Single 3-word frame on port 0.
    out_rd_en = 1'b1;
    t0 = cyc;
    first_valid_cyc = -1;
    push_src(0, 1, 3);
    push_exp(0, 1, 3);
    cycle();
    chk("t1_grant_after_arb", 72'(grant), 72'(4'b0001));
    run(15);
    chk("t1_latency", 72'(first_valid_cyc - t0), 72'(2));
    chk("t1_frames", 72'(frames_sent), 72'(1));
    chk("t1_grant_idle", 72'(grant), 72'(0));
    chk("t1_drop", 72'(drop_cnt), 72'(0));
    compare_out("t1");

    // Two frames per port queued at once: strict 0,1,2,3,0,1,2,3 order.
    do_reset();
    out_rd_en = 1'b1;
    for (int p = 0; p < NPORT; p++) begin
      push_src(p, 0, 3 + p);
      push_src(p, 1, 2 + p);
    end
    for (int id = 0; id < 2; id++)
      for (int p = 0; p < NPORT; p++) push_exp(p, id, (id == 0) ? 3 + p : 2 + p);
    run(80);
    chk("t2_frames", 72'(frames_sent), 72'(8));
    chk("t2_drop", 72'(drop_cnt), 72'(0));
    compare_out("t2");

    // Garbage ahead of a frame on port 1: one IDLE (uncounted) and 5 DATA words.
    do_reset();
    out_rd_en = 1'b1;
    src_q[1].push_back(XGMII_IDLE_WORD);
    for (int k = 0; k < 5; k++) src_q[1].push_back({8'h00, 8'h19, 40'h0, 16'(k + 100)});
    push_src(1, 3, 4);
    push_exp(1, 3, 4);
    run(40);
    chk("t3_drop", 72'(drop_cnt), 72'(5));
    chk("t3_frames", 72'(frames_sent), 72'(1));
    compare_out("t3");

    // Runaway frame on port 2: truncation after MAX_WORDS, remainder drained.
    do_reset();
    out_rd_en = 1'b1;
    push_src(2, 0, MAX_WORDS + 10);
    for (int i = 0; i < MAX_WORDS; i++) exp_q.push_back(gen_word(2, 0, MAX_WORDS + 10, i));
    exp_q.push_back(XGMII_ABORT_WORD);
    run(MAX_WORDS + 40);
    chk("t4_drop", 72'(drop_cnt), 72'(10));
    chk("t4_frames", 72'(frames_sent), 72'(0));
    chk("t4_grant_idle", 72'(grant), 72'(0));
    chk("t4_src_empty", 72'(src_q[2].size()), 72'(0));
    compare_out("t4");

    // Serializer stall for 20 cycles mid-frame on port 3.
    do_reset();
    out_rd_en = 1'b1;
    push_src(3, 5, 8);
    push_exp(3, 5, 8);
    n = 0;
    while (obs_q.size() < 3 && n < 40) begin
      cycle();
      n++;
    end
    chk("t5_reached_stall", 72'(obs_q.size() >= 3), 72'(1));
    out_rd_en = 1'b0;
    pops = 0;
    changes = 0;
    held = '0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      pops += $countones(rd_cap);
      if (i == 0) held = dout_cap;
      else if (dout_cap !== held) changes++;
    end
    chk("t5_stall_pops", 72'(pops), 72'(0));
    chk("t5_stall_dout_changes", 72'(changes), 72'(0));
    chk("t5_stall_valid", 72'(out_empty), 72'(0));
    out_rd_en = 1'b1;
    run(30);
    chk("t5_frames", 72'(frames_sent), 72'(1));
    compare_out("t5");

    // Reset mid-frame on port 0, then a frame on port 1.
    do_reset();
    out_rd_en = 1'b1;
    push_src(0, 1, 10);
    n = 0;
    while (obs_q.size() < 4 && n < 40) begin
      cycle();
      n++;
    end
    chk("t6_reached_midframe", 72'(obs_q.size() >= 4), 72'(1));
    sys_rst = 1'b0;
    #1;
    chk("t6_rst_out_empty", 72'(out_empty), 72'(1));
    chk("t6_rst_out_dout", out_dout, XGMII_IDLE_WORD);
    chk("t6_rst_rd_en", 72'(in_rd_en), 72'(0));
    leftover = src_q[0].size();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    obs_q.delete();
    exp_q.delete();
    push_src(1, 2, 3);
    push_exp(1, 2, 3);
    run(40);
    chk("t6_drop", 72'(drop_cnt), 72'(leftover));
    chk("t6_frames", 72'(frames_sent), 72'(1));
    chk("t6_src0_empty", 72'(src_q[0].size()), 72'(0));
    compare_out("t6");

    chk("pop_of_empty_source", 72'(underflow), 72'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo72_tx_arb.md
Name: fifo72_tx_arb

Overview:
- Frame-level round-robin arbiter between NPORT first-word-fall-through 72-bit FIFOs; all sources use XGMII word format (dout[71:64] = per-lane ctrl, lane i byte = dout[8i+7:8i]).
- Presents a single FWFT FIFO-style read interface (dout/empty/rd_en) to the fifo72toxgmii serializer, so multiple frame sources share one 10G TX path.
- Whole frames only: no interleaving, resync on garbage, watchdog truncation of runaway frames, plus status counters.

Parameters:
- NPORT, 4, number of source FIFOs (2..8).
- MAX_WORDS, 194, maximum 72-bit words per frame, SOF through EOF inclusive, before forced termination.

Ports:
- sys_clk  in  1  TX-domain clock; same clock as xgmii_tx_clk of the downstream serializer.
- sys_rst  in  1  asynchronous, active-low reset.
- in_dout  in  NPORT*72  source FIFO head words; port p = [72p+71:72p].
- in_empty  in  NPORT  source FIFO empty flags.
- in_rd_en  out  NPORT  source pop strobes.
- out_dout  out  72  head word toward serializer.
- out_empty  out  1  output not valid.
- out_rd_en  in  1  serializer pop.
- grant  out  NPORT  one-hot port currently owning the output; 0 when idle.
- frames_sent  out  32  completed frames (wraps).
- drop_cnt  out  16  discarded words (saturates at 16'hFFFF).

Behaviour:
- Word classes:
  - SOF: ctrl==8'h01 and byte0==8'hFB.
  - EOF: any lane i with ctrl[i]=1 and byte i==8'hFD.
  - IDLE: ctrl==8'hFF and not EOF.
  - DATA: anything else.
- Reset (sys_rst=0, async): state=ARB, out_empty=1, out_dout=72'hFF_0707070707070707, in_rd_en=0, grant=0, frames_sent=0, drop_cnt=0, rr pointer=NPORT-1, word count=0.
- Output buffer: one register stage.
  - out_empty = ~ob_valid.
  - Load enable ld = ~ob_valid | out_rd_en.
  - ob_valid clears when out_rd_en pops and nothing is loaded.
  - out_rd_en while out_empty=1 is ignored.
- State ARB:
  - Every non-empty port whose head is IDLE or DATA is popped the same cycle.
  - drop_cnt increments by the number of DATA words popped; IDLE words are not counted.
  - Among ports with an SOF head, pick the first at or after rr+1, modulo NPORT.
  - Grant is registered; next state SEND; word count=0; the SOF word is not popped in ARB.
- State SEND (grant port g):
  - If ld and ~in_empty[g]: in_rd_en[g]=1, ob<=in_dout[g], count+1.
  - If the popped word is EOF: frames_sent+1, rr<=g, grant<=0, next state ARB.
  - A SOF seen mid-frame is forwarded unchanged.
  - If ld and count==MAX_WORDS and no EOF yet: do not pop; load abort word 72'hFF_07070707070707FD; next state DRAIN; frames_sent unchanged.
- State DRAIN:
  - Pop g every cycle it is non-empty; drop_cnt+1 per word.
  - The EOF word is popped and counted; then rr<=g, grant<=0, next state ARB.
- in_rd_en is combinational from registered state, in_empty, heads and ld. At most one bit is set in SEND or DRAIN.
- Latency:
  - SOF at a source head with the output free: out_empty falls on the 2nd rising edge (arbitrate, then load).
  - Back-to-back frames: one bubble cycle per frame boundary (ARB cycle).
  - Full-rate streaming within a frame.
- Upstream empty mid-frame: hold state and the grant; no timeout.
- Reset mid-frame: output empties immediately. Leftover words of the partial frame are later discarded in ARB as DATA and counted.

Decomposition:
- Shared package:
  - XGMII constants: IDLE word, SOF ctrl/byte FB, terminate FD, abort word.
  - Classification functions is_sof / is_eof / is_idle.
  - State encoding ARB/SEND/DRAIN.
- Sub-module rr_pick: combinational NPORT-way round-robin priority picker (request vector, last pointer -> one-hot grant, valid).

Test Plan:
- Single 3-word frame on port 0 (FB... / data / FD in lane 3), out_rd_en=1 -> three words out unchanged, out_empty low 2 cycles after in_empty[0] falls, frames_sent=1, grant returns to 0.
- Ports 0..3 each queue two frames simultaneously -> output order 0,1,2,3,0,1,2,3; no interleaved words; frames_sent=8.
- Port 1 head holds 5 DATA words then an SOF frame -> 5 words popped in ARB, drop_cnt=5, the frame is forwarded intact.
- Port 2 frame of MAX_WORDS+10 words, no EOF until the last word -> MAX_WORDS words forwarded, then 72'hFF_07070707070707FD. The remaining 10 words (including the EOF) are dropped, drop_cnt=10, frames_sent=0.
- Serializer stalls (out_rd_en=0 for 20 cycles mid-frame) -> out_dout held stable, no source pops, no word lost or duplicated.
- sys_rst asserted mid-frame on port 0 -> out_empty=1 immediately. After release, the rest of the frame is dropped and counted, and the next SOF on port 1 is sent.
